// File: rtl/histeq_pkg.sv
// Shared constants and the frame-reader state encoding for the histogram-equalization pipeline.
package histeq_pkg;

    localparam int unsigned IMAGE_SIZE_DEFAULT = 640 * 480;
    localparam int unsigned PIXEL_W_DEFAULT    = 8;
    localparam int unsigned ADDR_W_DEFAULT     = 19;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        DONE_WAIT = 2'd2
    } reader_state_e;

endpackage : histeq_pkg

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO between the frame-buffer BRAM and the output stream.
// The head entry is presented on data_o/valid_o; push and pop may coincide.
module pixel_skid_fifo
    import histeq_pkg::*;
#(
    parameter int unsigned WIDTH = PIXEL_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             push_en,  pop_en;

    // Qualify push/pop against occupancy and compute next pointers and count.
    always_comb begin
        pop_en   = pop_i && (count_q != 2'd0);
        push_en  = push_i && ((count_q != 2'd2) || pop_en);
        wr_ptr_d = wr_ptr_q ^ push_en;
        rd_ptr_d = rd_ptr_q ^ pop_en;
        count_d  = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage entries; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule : pixel_skid_fifo

// File: rtl/image_frame_reader.sv
// Frame-buffer reader: streams exactly IMAGE_SIZE pixels in raster order from a
// synchronous BRAM as a valid/ready stream, one frame per rising read request.
module image_frame_reader
    import histeq_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE = IMAGE_SIZE_DEFAULT,
    parameter int unsigned PIXEL_W    = PIXEL_W_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_rd_image,
    output logic               o_mem_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [PIXEL_W-1:0] i_mem_data,
    output logic [PIXEL_W-1:0] o_pixel_data,
    output logic               o_pixel_valid,
    input  logic               i_pixel_ready,
    output logic               o_last,
    output logic               o_frame_done,
    output logic               o_busy
);

    localparam int unsigned      CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(IMAGE_SIZE);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IMAGE_SIZE - 1);

    reader_state_e    state_q,      state_d;
    logic [CNT_W-1:0] issued_q,     issued_d;
    logic [CNT_W-1:0] delivered_q,  delivered_d;
    logic             inflight_q,   inflight_d;
    logic             frame_done_q, frame_done_d;

    logic [1:0]       fifo_count;
    logic             fifo_valid;
    logic [PIXEL_W-1:0] fifo_data;
    logic             pop;
    logic             issue;
    logic [2:0]       occ_after_pop;

    pixel_skid_fifo #(
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk_i     (i_clk),
        .reset_n_i (i_reset_n),
        .push_i    (inflight_q),
        .data_i    (i_mem_data),
        .pop_i     (pop),
        .data_o    (fifo_data),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    // Issue gating: a read may only be launched if its data will have a FIFO slot,
    // counting the read already in flight and crediting a pop this cycle.
    always_comb begin
        pop           = fifo_valid && i_pixel_ready;
        occ_after_pop = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue         = (state_q == READ) && i_rd_image &&
                        (issued_q < SIZE_C) && (occ_after_pop < 3'd2);
    end

    // Next-state logic for the FSM, address/delivery counters and done pulse.
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        delivered_d  = delivered_q;
        inflight_d   = issue;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rd_image) begin
                    state_d     = READ;
                    issued_d    = '0;
                    delivered_d = '0;
                end
            end
            READ: begin
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                end
                if (pop) begin
                    delivered_d = delivered_q + 1'b1;
                end
                if (delivered_d == SIZE_C) begin
                    state_d      = DONE_WAIT;
                    frame_done_d = 1'b1;
                end
            end
            DONE_WAIT: begin
                if (!i_rd_image) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset abandons any partial frame.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            delivered_q  <= '0;
            inflight_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            delivered_q  <= delivered_d;
            inflight_q   <= inflight_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_mem_en      = issue;
    assign o_mem_addr    = issue ? issued_q[ADDR_W-1:0] : '0;
    assign o_pixel_data  = fifo_data;
    assign o_pixel_valid = fifo_valid;
    assign o_last        = fifo_valid && (state_q == READ) && (delivered_q == LAST_C);
    assign o_frame_done  = frame_done_q;
    assign o_busy        = (state_q != IDLE);

endmodule : image_frame_reader

// File: tb/tb_image_frame_reader.sv
// Directed bench for image_frame_reader: a 16-pixel instance covers streaming,
// backpressure, pause, hold-after-done and mid-frame reset; a 4-pixel instance
// covers start-up under full backpressure.
module tb_image_frame_reader;

    localparam int unsigned SIZE_A = 16;
    localparam int unsigned AW_A   = 4;
    localparam int unsigned SIZE_B = 4;
    localparam int unsigned AW_B   = 2;
    localparam int unsigned PW     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            rd_a, ready_a, mem_en_a, valid_a, last_a, done_a, busy_a;
    logic [AW_A-1:0] addr_a;
    logic [PW-1:0]   mem_data_a, data_a;

    logic            rd_b, ready_b, mem_en_b, valid_b, last_b, done_b, busy_b;
    logic [AW_B-1:0] addr_b;
    logic [PW-1:0]   mem_data_b, data_b;

    image_frame_reader #(.IMAGE_SIZE(SIZE_A), .PIXEL_W(PW), .ADDR_W(AW_A)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_image(rd_a),
        .o_mem_en(mem_en_a), .o_mem_addr(addr_a), .i_mem_data(mem_data_a),
        .o_pixel_data(data_a), .o_pixel_valid(valid_a), .i_pixel_ready(ready_a),
        .o_last(last_a), .o_frame_done(done_a), .o_busy(busy_a)
    );

    image_frame_reader #(.IMAGE_SIZE(SIZE_B), .PIXEL_W(PW), .ADDR_W(AW_B)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_rd_image(rd_b),
        .o_mem_en(mem_en_b), .o_mem_addr(addr_b), .i_mem_data(mem_data_b),
        .o_pixel_data(data_b), .o_pixel_valid(valid_b), .i_pixel_ready(ready_b),
        .o_last(last_b), .o_frame_done(done_b), .o_busy(busy_b)
    );

    // Synchronous BRAM models: pixel at address i is 0xA0+i (A) or 0xC0+i (B).
    always @(posedge clk) if (mem_en_a) mem_data_a <= 8'hA0 + 8'(addr_a);
    always @(posedge clk) if (mem_en_b) mem_data_b <= 8'hC0 + 8'(addr_b);

    int errors = 0;
    int checks = 0;
    int issA[$], rxA[$], lastA[$];
    int issB[$], rxB[$], lastB[$];
    int outA, outB, max_out, stab_err;
    logic stall_a, stall_b;
    logic [PW-1:0] held_a, held_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        issA.delete(); rxA.delete(); lastA.delete();
        issB.delete(); rxB.delete(); lastB.delete();
        outA = 0; outB = 0; max_out = 0; stab_err = 0;
        stall_a = 1'b0; stall_b = 1'b0;
    endtask

    // Log issues and transfers that the coming posedge will commit.
    task automatic record();
        if (stall_a && !(valid_a === 1'b1 && data_a === held_a)) stab_err++;
        if (stall_b && !(valid_b === 1'b1 && data_b === held_b)) stab_err++;
        stall_a = (valid_a === 1'b1) && (ready_a === 1'b0); held_a = data_a;
        stall_b = (valid_b === 1'b1) && (ready_b === 1'b0); held_b = data_b;
        if (mem_en_a === 1'b1) begin issA.push_back(int'(addr_a)); outA++; end
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            rxA.push_back(int'(data_a)); lastA.push_back(int'(last_a)); outA--;
        end
        if (mem_en_b === 1'b1) begin issB.push_back(int'(addr_b)); outB++; end
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            rxB.push_back(int'(data_b)); lastB.push_back(int'(last_b)); outB--;
        end
        if (outA > max_out) max_out = outA;
        if (outB > max_out) max_out = outB;
    endtask

    // Inputs are changed at negedge; one step crosses exactly one posedge.
    task automatic step();
        #1;
        record();
        @(negedge clk);
    endtask

    task automatic run_until_done_a(input int bound, output int steps);
        steps = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (done_a === 1'b1) begin
                steps = i;
                break;
            end
        end
    endtask

    task automatic check_frame_a(input string tag);
        chk({tag, "_nxfer"}, 32'(rxA.size()), SIZE_A);
        chk({tag, "_niss"}, 32'(issA.size()), SIZE_A);
        for (int i = 0; i < int'(SIZE_A); i++) begin
            if (i < rxA.size()) begin
                chk({tag, "_data"}, 32'(rxA[i]), 32'('hA0 + i));
                chk({tag, "_last"}, 32'(lastA[i]), 32'(i == int'(SIZE_A) - 1));
            end
            if (i < issA.size()) chk({tag, "_addr"}, 32'(issA[i]), 32'(i));
        end
    endtask

    int s;
    logic found;

    initial begin
        rst_n = 1'b0; rd_a = 1'b0; ready_a = 1'b1; rd_b = 1'b0; ready_b = 1'b0;
        clear();
        @(negedge clk);
        step();
        step();
        chk("rst_mem_en",  32'(mem_en_a), 0);
        chk("rst_addr",    32'(addr_a),   0);
        chk("rst_valid",   32'(valid_a),  0);
        chk("rst_data",    32'(data_a),   0);
        chk("rst_last",    32'(last_a),   0);
        chk("rst_done",    32'(done_a),   0);
        chk("rst_busy",    32'(busy_a),   0);
        chk("rst_busy_b",  32'(busy_b),   0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy_a), 0);

        // Frame 1: ready held high, first valid sampled at N+3, done at N+19.
        clear(); rd_a = 1'b1;
        step();
        chk("s1_busy_n",   32'(busy_a),  1);
        chk("s1_valid_n",  32'(valid_a), 0);
        step();
        chk("s1_valid_n1", 32'(valid_a), 0);
        step();
        chk("s1_valid_n2", 32'(valid_a), 1);
        chk("s1_data_n2",  32'(data_a),  32'h00A0);
        run_until_done_a(30, s);
        chk("s1_done_edge", 32'(s + 3), 19);
        chk("s1_busy_dw", 32'(busy_a), 1);
        check_frame_a("s1");
        chk("s1_occ", 32'(max_out <= 2), 1);

        // Request held high after done: no retrigger, one-cycle done pulse.
        step();
        chk("s4_done_pulse", 32'(done_a), 0);
        repeat (19) step();
        chk("s4_no_reads", 32'(issA.size()), SIZE_A);
        chk("s4_busy",     32'(busy_a), 1);
        chk("s4_valid",    32'(valid_a), 0);
        rd_a = 1'b0;
        step();
        chk("s4_idle", 32'(busy_a), 0);

        // Frame 2: ready toggling every cycle.
        clear(); rd_a = 1'b1; ready_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done_a === 1'b1) begin
                found = 1'b1;
                break;
            end
            ready_a = ~ready_a;
        end
        ready_a = 1'b1;
        chk("s2_done", 32'(found), 1);
        check_frame_a("s2");
        chk("s2_stable", 32'(stab_err), 0);
        chk("s2_occ", 32'(max_out <= 2), 1);
        rd_a = 1'b0;
        step();

        // Frame 3: pause the request after five issues.
        clear(); rd_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (issA.size() == 5) break;
        end
        chk("s3_five", 32'(issA.size()), 5);
        rd_a = 1'b0;
        repeat (10) step();
        chk("s3_paused_iss", 32'(issA.size()), 5);
        chk("s3_drained",    32'(rxA.size()),  5);
        chk("s3_busy",       32'(busy_a), 1);
        chk("s3_valid",      32'(valid_a), 0);
        rd_a = 1'b1;
        run_until_done_a(40, s);
        chk("s3_done", 32'(s != -1), 1);
        check_frame_a("s3");
        rd_a = 1'b0;
        step();

        // Frame 4: reset while pixel 7 is at the head, then a fresh frame.
        clear(); rd_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rxA.size() == 7) break;
        end
        chk("s5_seven", 32'(rxA.size()), 7);
        chk("s5_head", 32'(data_a), 32'h00A7);
        rst_n = 1'b0;
        step();
        chk("s5_mem_en", 32'(mem_en_a), 0);
        chk("s5_addr",   32'(addr_a),   0);
        chk("s5_valid",  32'(valid_a),  0);
        chk("s5_data",   32'(data_a),   0);
        chk("s5_last",   32'(last_a),   0);
        chk("s5_done",   32'(done_a),   0);
        chk("s5_busy",   32'(busy_a),   0);
        rst_n = 1'b1;
        clear();
        run_until_done_a(30, s);
        chk("s5_done_edge", 32'(s), 19);
        check_frame_a("s5");
        rd_a = 1'b0;
        step();

        // Small instance: ready low from the start, then released.
        clear(); rd_b = 1'b1;
        repeat (10) step();
        chk("s6_two_reads", 32'(issB.size()), 2);
        chk("s6_valid",     32'(valid_b), 1);
        chk("s6_head",      32'(data_b), 32'h00C0);
        chk("s6_no_xfer",   32'(rxB.size()), 0);
        chk("s6_no_last",   32'(last_b), 0);
        ready_b = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_b === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("s6_done", 32'(found), 1);
        chk("s6_nxfer", 32'(rxB.size()), SIZE_B);
        chk("s6_niss",  32'(issB.size()), SIZE_B);
        for (int i = 0; i < int'(SIZE_B); i++) begin
            if (i < rxB.size()) begin
                chk("s6_data", 32'(rxB[i]), 32'('hC0 + i));
                chk("s6_last", 32'(lastB[i]), 32'(i == int'(SIZE_B) - 1));
            end
            if (i < issB.size()) chk("s6_addr", 32'(issB[i]), 32'(i));
        end
        chk("s6_stable", 32'(stab_err), 0);
        chk("s6_occ", 32'(max_out <= 2), 1);
        rd_b = 1'b0;
        step();
        chk("s6_idle", 32'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_image_frame_reader

// File: doc/image_frame_reader.md
Name: image_frame_reader

Overview:
- Frame-buffer reader: serves read requests from the histogram-equalization sequencer by streaming one full image from a synchronous frame-buffer BRAM as a valid/ready pixel stream.
- Used for both passes of a frame, the histogram pass and the mapping pass.
- Its o_pixel_valid feeds the sequencer's pixel counter and the histogram/mapping datapaths.
- Guarantees exactly IMAGE_SIZE pixels per request, in raster order, with backpressure.

Parameters:
- IMAGE_SIZE, 640*480: pixels per frame; also the BRAM depth in use.
- PIXEL_W, 8: pixel width in bits.
- ADDR_W, 19: BRAM address width; must satisfy 2**ADDR_W >= IMAGE_SIZE.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, synchronous, active-low; clock i_clk.
- i_rd_image  in  1  level read request from sequencer; rising level starts a frame; low pauses issue.
- o_mem_en  out  1  BRAM read enable.
- o_mem_addr  out  ADDR_W  BRAM read address.
- i_mem_data  in  PIXEL_W  BRAM read data, valid exactly 1 cycle after o_mem_en.
- o_pixel_data  out  PIXEL_W  streamed pixel.
- o_pixel_valid  out  1  pixel valid.
- i_pixel_ready  in  1  downstream ready; a transfer occurs when valid && ready.
- o_last  out  1  high with the final pixel of the frame.
- o_frame_done  out  1  one-cycle pulse after the final transfer.
- o_busy  out  1  high in READ and DONE_WAIT.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - Outputs: o_mem_en=0, o_mem_addr=0, o_pixel_valid=0, o_pixel_data=0, o_last=0, o_frame_done=0, o_busy=0.
  - Internal: state=IDLE, issue and delivery counters=0, buffer emptied, in-flight flag cleared.
  - Reset mid-frame discards all buffered and in-flight data; no partial frame resumes.
- States:
  - IDLE: if i_rd_image=1, go to READ and clear both counters.
  - READ: issue reads and deliver pixels. When delivered count reaches IMAGE_SIZE, go to DONE_WAIT.
  - DONE_WAIT: wait for i_rd_image=0, then go to IDLE. A request still high after a frame never retriggers a second frame.
- Read issue, in READ only:
  - Issue condition: i_rd_image=1, issued < IMAGE_SIZE, and (buffer entries + in-flight − pop_this_cycle) < 2.
  - On issue: o_mem_en=1 and o_mem_addr=issued count.
  - Addresses run 0..IMAGE_SIZE−1 and never wrap. No read is issued past IMAGE_SIZE−1.
- Buffering:
  - A 2-entry FIFO sits between BRAM and output. Each in-flight read writes i_mem_data into it the cycle after issue.
  - The head entry drives o_pixel_data/o_pixel_valid.
  - The occupancy rule guarantees no overflow.
  - Push and pop in the same cycle are legal and keep occupancy constant.
- Latency:
  - First o_pixel_valid is 3 cycles after the edge where i_rd_image is first sampled high in IDLE (edge N→READ, N+1 issue addr 0, N+2 data captured, N+3 valid).
  - With i_pixel_ready held high, throughput is 1 pixel/cycle after the first.
  - Full frame: o_frame_done at edge N+3+IMAGE_SIZE.
- Backpressure:
  - o_pixel_valid/o_pixel_data are held stable while ready=0.
  - Issue stalls when the occupancy rule fails.
  - No pixel is dropped or duplicated.
- Pause: i_rd_image low during READ stops new issues only. The in-flight read still lands and buffered pixels still drain. Issue resumes from the same address when the request returns high.
- o_last: asserted with the pixel whose index is IMAGE_SIZE−1.
- o_frame_done: pulses 1 cycle after that pixel's transfer edge, coincident with entry to DONE_WAIT.
- Counters: width ADDR_W+1 so that the count IMAGE_SIZE is representable.

Decomposition:
- Shared package histeq_pkg holds:
  - default IMAGE_SIZE and PIXEL_W constants, shared with the sequencer and the histogram block;
  - reader state encoding localparams IDLE=0, READ=1, DONE_WAIT=2.
- One sub-module, pixel_skid_fifo: 2-entry FIFO with push/pop/occupancy.
- The top level holds the FSM, counters, issue logic and o_last/o_frame_done.

Test Plan:
- IMAGE_SIZE=16, BRAM[i]=i, ready=1, raise rd at edge N → valid first at N+3. Data 0..15 on consecutive cycles, o_last on data 15, o_frame_done pulse at N+19, no further o_mem_en.
- IMAGE_SIZE=16, ready toggled 1/0 each cycle → 16 transfers of 0..15 in order. Data stable while ready=0; FIFO occupancy never exceeds 2.
- Drop rd after 5 issues for 10 cycles, then restore → in-flight data still delivered. Issue resumes at address 5; the frame completes with 16 unique pixels.
- Hold rd high after o_frame_done for 20 cycles → no new reads, state stays DONE_WAIT. Drop rd then raise again → second frame starts at address 0 (sequencer two-pass flow).
- Assert i_reset_n=0 mid-frame at pixel 7 → next cycle all outputs 0 and state IDLE. A new request reads from address 0.
- ready=0 from start with IMAGE_SIZE=4 → exactly 2 reads issued then stall. Releasing ready yields 0,1,2,3 with o_last on 3.
